mux_n_to_1_pipe: RTL and testbench

- Parametrised N-input, W-bit selector with valid/ready handshakes and a registered 2-entry output skid buffer.
- Source is chosen either by an external select (fixed mode) or by an internal round-robin arbiter.
- Used in the MIPS32 datapath wherever several producers share one consumer (PC source, writeback source, memory-request merge), replacing combinational 2:1 selection where a timing break and back-pressure are needed.

---
 rtl/mips_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_n_to_1_pipe.sv | 135 +++++++++++++
 tb/tb_mux_n_to_1_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath constants: selector modes and an elaboration-time clog2 helper.
package mips_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // Constant-index compare keeps the search free of variable bit selects.
    always_comb begin
        int unsigned idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (!gnt_valid && (j == idx) && req[j]) begin
                    gnt_valid = 1'b1;
                    gnt[j]    = 1'b1;
                    gnt_idx   = SEL_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// N-input selector with valid/ready handshakes, fixed or round-robin source choice,
// and a 2-entry registered output skid buffer.
module mux_n_to_1_pipe
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (SEL_W < clog2(N_IN)) begin : g_sel_w_check
        $error("mux_n_to_1_pipe: SEL_W too narrow for N_IN");
    end

    // Entry 0 is the head; entry 1 is only valid when entry 0 is.
    logic [WIDTH-1:0] data_q [2];
    logic [SEL_W-1:0] src_q  [2];
    logic [1:0]       vld_q;
    logic             space_q;
    logic [SEL_W-1:0] rr_ptr_q;

    logic [WIDTH-1:0] data_d [2];
    logic [SEL_W-1:0] src_d  [2];
    logic [1:0]       vld_d;

    logic [N_IN-1:0]  rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_valid;

    logic [N_IN-1:0]  grant_c;
    logic [WIDTH-1:0] push_data;
    logic [SEL_W-1:0] push_src;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] rr_ptr_d;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    // Grant vector and accepted payload; an out-of-range sel grants nothing.
    always_comb begin
        grant_c   = '0;
        push_data = '0;
        push_src  = '0;
        if (mode == MODE_RR) begin
            grant_c = rr_gnt;
        end else begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (32'(sel) == j) begin
                    grant_c[j] = 1'b1;
                end
            end
        end
        for (int unsigned j = 0; j < N_IN; j++) begin
            if (grant_c[j]) begin
                push_data = in_data[j*WIDTH +: WIDTH];
                push_src  = SEL_W'(j);
            end
        end
    end

    assign in_ready  = grant_c & {N_IN{space_q}};
    assign push      = |(in_valid & in_ready);
    assign pop       = vld_q[0] & out_ready;
    assign out_data  = data_q[0];
    assign out_src   = src_q[0];
    assign out_valid = vld_q[0];

    // Buffer next state: pop shifts entry 1 forward, push fills the first free slot.
    always_comb begin
        data_d   = data_q;
        src_d    = src_q;
        vld_d    = vld_q;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            data_d[0] = data_q[1];
            src_d[0]  = src_q[1];
            vld_d     = {1'b0, vld_q[1]};
        end
        if (push) begin
            if (!vld_d[0]) begin
                data_d[0] = push_data;
                src_d[0]  = push_src;
                vld_d[0]  = 1'b1;
            end else begin
                data_d[1] = push_data;
                src_d[1]  = push_src;
                vld_d[1]  = 1'b1;
            end
            if ((mode == MODE_RR) && rr_valid) begin
                rr_ptr_d = (32'(rr_idx) == N_IN - 1) ? '0 : SEL_W'(32'(rr_idx) + 1);
            end
        end
    end

    // space_q holds 0 through reset so nothing is accepted until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                src_q[i]  <= '0;
            end
            vld_q    <= '0;
            space_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            src_q    <= src_d;
            vld_q    <= vld_d;
            space_q  <= ~(vld_d[0] & vld_d[1]);
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed bench for mux_n_to_1_pipe with hand-computed expectations.
module tb_mux_n_to_1_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned SEL_W = 3;

    logic                  clk;
    logic                  rst_n;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;

    int n_checks;
    int n_fail;

    mux_n_to_1_pipe #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] val);
        in_data[idx*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 4'b1111;
        sel       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  out_data, 32'd0);
        check_eq("rst_out_src",   32'(out_src), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready), 32'd0);
        tick();
        tick();
        check_eq("rst_in_ready_held", 32'(in_ready), 32'd0);
        rst_n    = 1'b1;
        in_valid = '0;
        tick();
        tick();

        // Fixed mode, sel=2
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; out_ready = 1'b1;
        set_data(2, 32'hDEADBEEF);
        #1;
        check_eq("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check_eq("fix_out_valid", 32'(out_valid), 32'd1);
        check_eq("fix_out_data",  out_data, 32'hDEADBEEF);
        check_eq("fix_out_src",   32'(out_src), 32'd2);
        in_valid = '0;
        tick();
        check_eq("fix_drain_valid", 32'(out_valid), 32'd0);

        // Out-of-range select
        sel = 3'd5; in_valid = 4'b1111;
        #1;
        check_eq("oor_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_eq("oor_out_valid", 32'(out_valid), 32'd0);

        // Round-robin streaming, all requesting
        mode = 1'b1; sel = '0;
        for (int i = 0; i < 4; i++) set_data(i, 32'h100 + 32'(i));
        #1;
        check_eq("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("rr_seq_valid", 32'(out_valid), 32'd1);
            check_eq("rr_seq_src",   32'(out_src), 32'(k % 4));
            check_eq("rr_seq_data",  out_data, 32'h100 + 32'(k % 4));
        end
        // Pointer now 2: sparse requests exercise the wrap
        in_valid = 4'b1001;
        #1;
        check_eq("rr_skip_ready", 32'(in_ready), 32'b1000);
        tick();
        check_eq("rr_skip_src",   32'(out_src), 32'd3);
        check_eq("rr_wrap_ready", 32'(in_ready), 32'b0001);
        tick();
        check_eq("rr_wrap_src",   32'(out_src), 32'd0);
        check_eq("rr_next_ready", 32'(in_ready), 32'b1000);
        in_valid = '0;
        tick();
        check_eq("rr_drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure: fill both entries, then release
        mode = 1'b0; sel = 3'd1; out_ready = 1'b0; in_valid = 4'b0010;
        set_data(1, 32'hAAAA0001);
        tick();
        check_eq("bp_a_data",  out_data, 32'hAAAA0001);
        check_eq("bp_a_ready", 32'(in_ready), 32'b0010);
        set_data(1, 32'hBBBB0002);
        tick();
        check_eq("bp_full_ready", 32'(in_ready), 32'd0);
        check_eq("bp_hold_data",  out_data, 32'hAAAA0001);
        check_eq("bp_hold_src",   32'(out_src), 32'd1);
        tick();
        check_eq("bp_hold2_data", out_data, 32'hAAAA0001);
        in_valid = '0; out_ready = 1'b1;
        tick();
        check_eq("bp_b_valid", 32'(out_valid), 32'd1);
        check_eq("bp_b_data",  out_data, 32'hBBBB0002);
        tick();
        check_eq("bp_empty_valid", 32'(out_valid), 32'd0);

        // Simultaneous push/pop with one entry held
        sel = 3'd0; in_valid = 4'b0001;
        set_data(0, 32'hC0000000);
        tick();
        check_eq("pp_first_data", out_data, 32'hC0000000);
        for (int k = 1; k <= 10; k++) begin
            set_data(0, 32'hC0000000 + 32'(k));
            tick();
            check_eq("pp_data",  out_data, 32'hC0000000 + 32'(k));
            check_eq("pp_ready", 32'(in_ready), 32'b0001);
        end
        in_valid = '0;
        tick();
        check_eq("pp_drain_valid", 32'(out_valid), 32'd0);

        // Reset while full in RR mode (pointer left at 3)
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b0;
        tick();
        tick();
        check_eq("mid_full_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1; in_valid = '0;
        tick();
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        set_data(0, 32'h100);
        in_valid = 4'b1111;
        #1;
        check_eq("post_rst_rr_ready", 32'(in_ready), 32'b0001);
        out_ready = 1'b1;
        tick();
        check_eq("post_rst_src",  32'(out_src), 32'd0);
        check_eq("post_rst_data", out_data, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
